// File: rtl/rtype_instr_encoder_pkg.sv
// rtype_pkg: R-type opcode, ALU codes, funct fields and FSM states shared by encoder and decoder.
package rtype_pkg;
  localparam logic [6:0] OPCODE_R = 7'b0100001;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_MUL = 3'd2;
  localparam logic [2:0] F3_XOR = 3'd4;
  localparam logic [2:0] F3_SRL = 3'd5;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [2:0] F3_AND = 3'd7;
  localparam logic [6:0] F7_BASE = 7'd0;
  localparam logic [6:0] F7_SUB  = 7'd32;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FULL = 2'd2;
  // Illegal codes (bit 3 set) encode as ADD; callers must filter them out.
  function automatic logic [31:0] encode(input logic [3:0] alu, input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    logic [2:0] f3;
    f3 = alu == ALU_OR  ? F3_OR  :
         alu == ALU_AND ? F3_AND :
         alu == ALU_SLL ? F3_SLL :
         alu == ALU_SRL ? F3_SRL :
         alu == ALU_MUL ? F3_MUL :
         alu == ALU_XOR ? F3_XOR : F3_ADD;
    return {alu == ALU_SUB ? F7_SUB : F7_BASE, rs2, rs1, f3, rd, OPCODE_R};
  endfunction
endpackage

// File: rtl/rtype_instr_encoder_if.sv
// rtype_instr_encoder_if: request stream, memory write port and status of the encoder.
interface rtype_instr_encoder_if #(parameter int ADDR_W = 8);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_alu_control;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              done;
  logic              err_illegal;
  logic [ADDR_W:0]   words_written;
  modport master (
    output start, in_valid, in_alu_control, in_rd, in_rs1, in_rs2, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, done, err_illegal, words_written
  );
  modport slave (
    input  start, in_valid, in_alu_control, in_rd, in_rs1, in_rs2, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, done, err_illegal, words_written
  );
endinterface

// File: rtl/rtype_instr_encoder_fifo2.sv
// rtype_fifo2: 2-entry valid/ready FIFO with synchronous clear; in_ready_o ignores a same-edge pop.
module rtype_fifo2 #(
  parameter int             W       = 40,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;
  logic         push, pop;
  assign in_ready_o  = cnt_q != 2'd2;
  assign out_valid_o = cnt_q != 2'd0;
  assign out_data_o  = mem_q[rp_q];
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr_i) begin
      mem_q <= '{default: RST_VAL};
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) mem_q[wp_q] <= in_data_i;
      wp_q  <= wp_q ^ push;
      rp_q  <= rp_q ^ pop;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/rtype_instr_encoder.sv
// rtype_instr_encoder: packs ALU operations into R-type words and streams them to instruction memory.
module rtype_instr_encoder
  import rtype_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 64
) (
  input logic clk,
  input logic rst_n,
  rtype_instr_encoder_if.slave bus
);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  state_t          state_q, state_d;
  logic [ADDR_W:0] resv_q, resv_d, words_q, words_d;
  logic            err_q, err_d;
  logic            fifo_ready, accept, legal, push, pop;
  assign legal       = !bus.in_alu_control[3];
  assign bus.in_ready = state_q == ST_RUN && !bus.start && fifo_ready && resv_q < DEPTH_C;
  assign accept      = bus.in_valid && bus.in_ready;
  assign push        = accept && legal;
  assign pop         = bus.wr_en && bus.wr_ready;
  always_comb begin
    resv_d  = bus.start ? '0 : resv_q + (ADDR_W+1)'(push);
    words_d = bus.start ? '0 : words_q + (ADDR_W+1)'(pop);
    err_d   = !bus.start && (err_q || (accept && !legal));
    state_d = bus.start ? ST_RUN : (state_q == ST_RUN && words_d == DEPTH_C) ? ST_FULL : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      resv_q  <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      resv_q  <= resv_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end
  // The reserved count doubles as the sequence index, so illegal codes leave no address gap.
  rtype_fifo2 #(.W(32 + ADDR_W), .RST_VAL({BASE_C, 32'h0})) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (bus.start),
    .in_valid_i  (push),
    .in_data_i   ({BASE_C + resv_q[ADDR_W-1:0],
                   encode(bus.in_alu_control, bus.in_rd, bus.in_rs1, bus.in_rs2)}),
    .in_ready_o  (fifo_ready),
    .out_valid_o (bus.wr_en),
    .out_data_o  ({bus.wr_addr, bus.wr_data}),
    .out_ready_i (bus.wr_ready)
  );
  assign bus.done          = state_q == ST_FULL;
  assign bus.err_illegal   = err_q;
  assign bus.words_written = words_q;
endmodule

// File: tb/tb_rtype_instr_encoder.sv
// tb_rtype_instr_encoder: directed tests of encoding, backpressure, illegal codes, depth limit and restart.
module tb_rtype_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [39:0] wq [$];
  rtype_instr_encoder_if #(.ADDR_W(8)) bus ();
  rtype_instr_encoder #(.ADDR_W(8), .BASE_ADDR(0), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rst_n && bus.wr_en && bus.wr_ready && !bus.start) wq.push_back({bus.wr_addr, bus.wr_data});
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic send(input logic [3:0] a, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    bit ok = 0;
    bus.in_alu_control = a;
    bus.in_rd = d;
    bus.in_rs1 = s1;
    bus.in_rs2 = s2;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        tick();
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: code %b not accepted, in_ready=%b required 1", a, bus.in_ready);
    end
  endtask
  task automatic test_reset();
    #2;
    checks += 7;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", bus.wr_en); end
    if (bus.wr_addr !== 8'h00) begin errors++; $display("FAIL rst_wr_addr: got %h want 00", bus.wr_addr); end
    if (bus.wr_data !== 32'h0) begin errors++; $display("FAIL rst_wr_data: got %h want 0", bus.wr_data); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
    if (bus.err_illegal !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err_illegal); end
    if (bus.words_written !== 9'd0) begin errors++; $display("FAIL rst_words: got %0d want 0", bus.words_written); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b want 0", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic test_add_latency();
    bus.wr_ready = 1'b1;
    do_start();
    wq.delete();
    bus.in_alu_control = 4'b0010;
    bus.in_rd = 5'd1;
    bus.in_rs1 = 5'd2;
    bus.in_rs2 = 5'd3;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL add_wr_en: got %b want 1", bus.wr_en); end
    if (bus.wr_addr !== 8'h00) begin errors++; $display("FAIL add_wr_addr: got %h want 00", bus.wr_addr); end
    if (bus.wr_data !== 32'h003100A1) begin errors++; $display("FAIL add_wr_data: got %h want 003100a1", bus.wr_data); end
    tick();
    @(negedge clk);
    checks += 2;
    if (bus.words_written !== 9'd1) begin errors++; $display("FAIL add_words: got %0d want 1", bus.words_written); end
    if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL add_drained: got %b want 0", bus.wr_en); end
    tick();
  endtask
  task automatic test_sub_xor();
    logic [39:0] exp [2] = '{{8'h00, 32'h407302A1}, {8'h01, 32'h00004021}};
    bus.wr_ready = 1'b1;
    do_start();
    wq.delete();
    send(4'b0100, 5'd5, 5'd6, 5'd7);
    send(4'b0111, 5'd0, 5'd0, 5'd0);
    repeat (3) tick();
    @(negedge clk);
    checks += 2;
    if (wq.size() != 2) begin errors++; $display("FAIL subxor_count: got %0d writes want 2", wq.size()); end
    if (bus.words_written !== 9'd2) begin errors++; $display("FAIL subxor_words: got %0d want 2", bus.words_written); end
    for (int i = 0; i < 2; i++) begin
      logic [39:0] got = i < wq.size() ? wq[i] : 40'hx;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL subxor_write%0d: got %h want %h", i, got, exp[i]); end
    end
    tick();
  endtask
  task automatic test_backpressure();
    logic [39:0] exp [3] = '{{8'h00, 32'h00C5E521}, {8'h01, 32'h01FFFFA1}, {8'h02, 32'h00821121}};
    bus.wr_ready = 1'b0;
    do_start();
    wq.delete();
    send(4'b0001, 5'd10, 5'd11, 5'd12);
    send(4'b0000, 5'd31, 5'd31, 5'd31);
    bus.in_alu_control = 4'b0011;
    bus.in_rd = 5'd2;
    bus.in_rs1 = 5'd4;
    bus.in_rs2 = 5'd8;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b1 || bus.wr_addr !== 8'h00 || bus.wr_data !== 32'h00C5E521) begin
        errors++;
        $display("FAIL bp_hold%0d: in_ready=%b wr_en=%b addr=%h data=%h want 0 1 00 00c5e521",
                 i, bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data);
      end
      tick();
    end
    bus.wr_ready = 1'b1;
    send(4'b0011, 5'd2, 5'd4, 5'd8);
    repeat (4) tick();
    @(negedge clk);
    checks += 2;
    if (wq.size() != 3) begin errors++; $display("FAIL bp_count: got %0d writes want 3", wq.size()); end
    if (bus.words_written !== 9'd3) begin errors++; $display("FAIL bp_words: got %0d want 3", bus.words_written); end
    for (int i = 0; i < 3; i++) begin
      logic [39:0] got = i < wq.size() ? wq[i] : 40'hx;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL bp_write%0d: got %h want %h", i, got, exp[i]); end
    end
    tick();
  endtask
  task automatic test_illegal();
    logic [39:0] exp [2] = '{{8'h00, 32'h003100A1}, {8'h01, 32'h002081A1}};
    bus.wr_ready = 1'b1;
    do_start();
    wq.delete();
    send(4'b0010, 5'd1, 5'd2, 5'd3);
    send(4'b1010, 5'd9, 5'd9, 5'd9);
    send(4'b0010, 5'd3, 5'd1, 5'd2);
    repeat (3) tick();
    @(negedge clk);
    checks += 3;
    if (bus.err_illegal !== 1'b1) begin errors++; $display("FAIL ill_err: got %b want 1", bus.err_illegal); end
    if (bus.words_written !== 9'd2) begin errors++; $display("FAIL ill_words: got %0d want 2", bus.words_written); end
    if (wq.size() != 2) begin errors++; $display("FAIL ill_count: got %0d writes want 2", wq.size()); end
    for (int i = 0; i < 2; i++) begin
      logic [39:0] got = i < wq.size() ? wq[i] : 40'hx;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL ill_write%0d: got %h want %h", i, got, exp[i]); end
    end
    tick();
  endtask
  task automatic test_depth();
    logic [39:0] exp [4] = '{{8'h00, 32'h0010D0A1}, {8'h01, 32'h0010A0A1}, {8'h02, 32'h003100A1}, {8'h03, 32'h00004021}};
    int n_ready = 0;
    bus.wr_ready = 1'b1;
    do_start();
    wq.delete();
    send(4'b0101, 5'd1, 5'd1, 5'd1);
    send(4'b0110, 5'd1, 5'd1, 5'd1);
    send(4'b0010, 5'd1, 5'd2, 5'd3);
    send(4'b0111, 5'd0, 5'd0, 5'd0);
    bus.in_alu_control = 4'b0010;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_ready += int'(bus.in_ready);
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks += 4;
    if (n_ready != 0) begin errors++; $display("FAIL depth_blocked: in_ready high %0d cycles want 0", n_ready); end
    if (wq.size() != 4) begin errors++; $display("FAIL depth_count: got %0d writes want 4", wq.size()); end
    if (bus.words_written !== 9'd4) begin errors++; $display("FAIL depth_words: got %0d want 4", bus.words_written); end
    if (bus.done !== 1'b1) begin errors++; $display("FAIL depth_done: got %b want 1", bus.done); end
    for (int i = 0; i < 4; i++) begin
      logic [39:0] got = i < wq.size() ? wq[i] : 40'hx;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL depth_write%0d: got %h want %h", i, got, exp[i]); end
    end
    tick();
  endtask
  task automatic test_start_flush();
    bus.wr_ready = 1'b0;
    do_start();
    wq.delete();
    send(4'b1111, 5'd1, 5'd1, 5'd1);
    send(4'b0010, 5'd1, 5'd2, 5'd3);
    send(4'b0100, 5'd5, 5'd6, 5'd7);
    @(negedge clk);
    checks += 2;
    if (bus.err_illegal !== 1'b1) begin errors++; $display("FAIL flush_err_set: got %b want 1", bus.err_illegal); end
    if (bus.wr_en !== 1'b1) begin errors++; $display("FAIL flush_pending: got %b want 1", bus.wr_en); end
    tick();
    bus.start = 1'b1;
    bus.wr_ready = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_start_mask: got %b want 0", bus.in_ready); end
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks += 4;
    if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL flush_wr_en: got %b want 0", bus.wr_en); end
    if (bus.words_written !== 9'd0) begin errors++; $display("FAIL flush_words: got %0d want 0", bus.words_written); end
    if (bus.err_illegal !== 1'b0) begin errors++; $display("FAIL flush_err_clr: got %b want 0", bus.err_illegal); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b want 0", bus.done); end
    tick();
    send(4'b0111, 5'd0, 5'd0, 5'd0);
    repeat (2) tick();
    @(negedge clk);
    checks += 3;
    if (wq.size() != 1) begin errors++; $display("FAIL flush_count: got %0d writes want 1", wq.size()); end
    if (wq.size() != 0 && wq[0] !== {8'h00, 32'h00004021}) begin
      errors++;
      $display("FAIL flush_next: got %h want 0000004021", wq[0]);
    end
    if (bus.words_written !== 9'd1) begin errors++; $display("FAIL flush_words_after: got %0d want 1", bus.words_written); end
    tick();
  endtask
  task automatic test_async_reset();
    bus.wr_ready = 1'b0;
    do_start();
    send(4'b0010, 5'd1, 5'd2, 5'd3);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL arst_wr_en: got %b want 0", bus.wr_en); end
    if (bus.wr_data !== 32'h0) begin errors++; $display("FAIL arst_wr_data: got %h want 0", bus.wr_data); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL arst_in_ready: got %b want 0", bus.in_ready); end
    if (bus.words_written !== 9'd0) begin errors++; $display("FAIL arst_words: got %0d want 0", bus.words_written); end
    tick();
    rst_n = 1'b1;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_alu_control = 4'b0;
    bus.in_rd = 5'd0;
    bus.in_rs1 = 5'd0;
    bus.in_rs2 = 5'd0;
    bus.wr_ready = 1'b0;
    test_reset();
    test_add_latency();
    test_sub_xor();
    test_backpressure();
    test_illegal();
    test_depth();
    test_start_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
